// File: rtl/ram_pkg.sv
// Shared RAM geometry defaults and reader FSM state encoding.
package ram_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/ram_rd_skid_buf.sv
// Two-entry FIFO with a registered head that drives the output stream directly.
// Carries a 'last' sideband bit; the caller must never push into a full buffer.
module ram_rd_skid_buf #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic                  head_last_q, head_last_d, tail_last_q, tail_last_d;
    logic [1:0]            count_q, count_d;
    logic                  pop;

    assign pop = (count_q != 2'd0) && out_ready;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        head_last_d = head_last_q;
        tail_last_d = tail_last_q;
        count_d     = count_q;
        case ({in_valid, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d      = in_data;
                    head_last_d = in_last;
                end else begin
                    tail_d      = in_data;
                    tail_last_d = in_last;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d      = tail_q;
                head_last_d = tail_last_q;
                count_d     = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word lands wherever the queue tail now is.
                if (count_q == 2'd1) begin
                    head_d      = in_data;
                    head_last_d = in_last;
                end else begin
                    head_d      = tail_q;
                    head_last_d = tail_last_q;
                    tail_d      = in_data;
                    tail_last_d = in_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            head_last_q <= 1'b0;
            tail_last_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            head_last_q <= head_last_d;
            tail_last_q <= tail_last_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign out_last  = head_last_q && out_valid;
    assign count     = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a contiguous RAM address range and streams the words out on valid/ready,
// absorbing the RAM's one-cycle read latency without losing words under backpressure.
module ram_stream_reader #(
    parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rdaddr,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    import ram_pkg::*;

    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] rdaddr_q, rdaddr_d;
    logic [ADDR_WIDTH:0]   issued_q, issued_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   last_idx;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [1:0]            buf_count;
    logic [2:0]            occupancy;
    logic                  pop, issue, issue_last;

    assign pop        = out_valid && out_ready;
    // A word leaving this cycle frees its slot in time for the issue on the same edge.
    assign occupancy  = 3'(inflight_q) + 3'(buf_count) - 3'(pop);
    assign issue      = (state_q == READ) && (occupancy < 3'd2);
    assign last_idx   = len_q - 1'b1;
    assign issue_last = (issued_q == last_idx);

    always_comb begin
        state_d         = state_q;
        rdaddr_d        = rdaddr_q;
        issued_d        = issued_q;
        len_d           = len_q;
        inflight_d      = issue;
        inflight_last_d = issue && issue_last;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rdaddr_d = base_addr;
                    len_d    = length;
                    issued_d = '0;
                    state_d  = (length == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (issue) begin
                    rdaddr_d = rdaddr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                    if (issue_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rdaddr_q        <= '0;
            issued_q        <= '0;
            len_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rdaddr_q        <= rdaddr_d;
            issued_q        <= issued_d;
            len_q           <= len_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    ram_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inflight_q),
        .in_data   (q),
        .in_last   (inflight_last_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .count     (buf_count)
    );

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign rdaddr = rdaddr_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader against a behavioural synchronous-read RAM.
module tb_ram_stream_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  base_addr;
    logic [5:0]  length;
    logic        busy;
    logic        done;
    logic [4:0]  rdaddr;
    logic [15:0] q;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic [15:0] mem [32];
    int n_checks;
    int n_fail;

    ram_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rdaddr    (rdaddr),
        .q         (q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) q <= mem[rdaddr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
        step(); step();
        n_checks++;
        if ({busy, done, out_valid, out_last} !== 4'b0000) begin
            $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, out_valid, out_last}); n_fail++;
        end
        n_checks++;
        if (out_data !== 16'h0 || rdaddr !== 5'd0) begin
            $display("FAIL reset_data: got data=%h addr=%0d expected 0/0", out_data, rdaddr); n_fail++;
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1; start = 1'b1; base_addr = 5'd3; length = 6'd4;
        step(); start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || rdaddr !== 5'd3 || out_valid !== 1'b0) begin
            $display("FAIL basic_e0: got busy=%b addr=%0d valid=%b expected 1/3/0", busy, rdaddr, out_valid); n_fail++;
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL basic_e1_valid: got %b expected 0", out_valid); n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 16'hA003 + 16'(i) || out_last !== (i == 3) || done !== 1'b0) begin
                $display("FAIL basic_word%0d: got v=%b d=%h l=%b done=%b expected 1/%h/%b/0",
                         i, out_valid, out_data, out_last, done, 16'hA003 + 16'(i), (i == 3)); n_fail++;
            end
        end
        step();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL basic_done: got done=%b busy=%b valid=%b expected 1/1/0", done, busy, out_valid); n_fail++;
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_idle: got done=%b busy=%b expected 0/0", done, busy); n_fail++;
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_w [4];
        exp_w[0] = 16'hA01E; exp_w[1] = 16'hA01F; exp_w[2] = 16'hA000; exp_w[3] = 16'hA001;
        out_ready = 1'b1; start = 1'b1; base_addr = 5'd30; length = 6'd4;
        step(); start = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w[i] || out_last !== (i == 3)) begin
                $display("FAIL wrap_word%0d: got v=%b d=%h l=%b expected 1/%h/%b",
                         i, out_valid, out_data, out_last, exp_w[i], (i == 3)); n_fail++;
            end
        end
        step();
        n_checks++;
        if (done !== 1'b1) begin
            $display("FAIL wrap_done: got %b expected 1", done); n_fail++;
        end
        step();
    endtask

    task automatic test_backpressure();
        int got, issued, ahead;
        logic stall_prev, last_prev, done_seen;
        logic [15:0] data_prev;
        logic [4:0]  addr_prev;
        got = 0; issued = 0; stall_prev = 0; last_prev = 0; data_prev = '0; done_seen = 0;
        out_ready = 1'b0; start = 1'b1; base_addr = 5'd0; length = 6'd32;
        step(); start = 1'b0;
        addr_prev = rdaddr;
        for (int cyc = 0; cyc < 600 && !done_seen; cyc++) begin
            if (stall_prev) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== data_prev || out_last !== last_prev) begin
                    $display("FAIL bp_stable: got v=%b d=%h l=%b expected 1/%h/%b",
                             out_valid, out_data, out_last, data_prev, last_prev); n_fail++;
                end
            end
            issued = issued + int'(5'(rdaddr - addr_prev));
            addr_prev = rdaddr;
            ahead = issued - got;
            n_checks++;
            if (ahead > 2) begin
                $display("FAIL bp_ahead: got %0d words ahead expected <= 2", ahead); n_fail++;
            end
            if (done) done_seen = 1;
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_data !== 16'hA000 + 16'(got) || out_last !== (got == 31)) begin
                    $display("FAIL bp_word%0d: got d=%h l=%b expected %h/%b",
                             got, out_data, out_last, 16'hA000 + 16'(got), (got == 31)); n_fail++;
                end
                got++;
            end
            stall_prev = out_valid && !out_ready;
            data_prev = out_data;
            last_prev = out_last;
            step();
        end
        n_checks++;
        if (got != 32 || !done_seen) begin
            $display("FAIL bp_count: got %0d words done=%b expected 32/1", got, done_seen); n_fail++;
        end
        out_ready = 1'b1;
        step(); step();
    endtask

    task automatic test_zero_length();
        out_ready = 1'b1; start = 1'b1; base_addr = 5'd7; length = 6'd0;
        step(); start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL zero_done: got done=%b busy=%b valid=%b expected 1/1/0", done, busy, out_valid); n_fail++;
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL zero_idle: got done=%b busy=%b valid=%b expected 0/0/0", done, busy, out_valid); n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin
                $display("FAIL zero_valid: got %b expected 0", out_valid); n_fail++;
            end
        end
    endtask

    task automatic test_start_while_busy();
        int got, dones;
        got = 0; dones = 0;
        out_ready = 1'b1; start = 1'b1; base_addr = 5'd10; length = 6'd5;
        step();
        start = 1'b1; base_addr = 5'd0; length = 6'd2;
        step(); start = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done) dones++;
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_data !== 16'hA00A + 16'(got)) begin
                    $display("FAIL busy_word%0d: got %h expected %h", got, out_data, 16'hA00A + 16'(got)); n_fail++;
                end
                got++;
            end
            step();
        end
        n_checks++;
        if (got != 5 || dones != 1) begin
            $display("FAIL busy_count: got words=%0d dones=%0d expected 5/1", got, dones); n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        int sent;
        sent = 0;
        out_ready = 1'b1; start = 1'b1; base_addr = 5'd8; length = 6'd8;
        step(); start = 1'b0;
        for (int cyc = 0; cyc < 50 && sent < 3; cyc++) begin
            if (out_valid) sent++;
            step();
        end
        out_ready = 1'b0;
        step(); step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA00B) begin
            $display("FAIL mid_stall: got v=%b d=%h expected 1/a00b", out_valid, out_data); n_fail++;
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, out_valid, out_last} !== 4'b0000 || out_data !== 16'h0 || rdaddr !== 5'd0) begin
            $display("FAIL mid_reset: got ctrl=%b d=%h a=%0d expected 0000/0/0",
                     {busy, done, out_valid, out_last}, out_data, rdaddr); n_fail++;
        end
        step(); rst_n = 1'b1;
        step();
        out_ready = 1'b1; start = 1'b1; base_addr = 5'd20; length = 6'd3;
        step(); start = 1'b0;
        n_checks++;
        if (rdaddr !== 5'd20 || out_valid !== 1'b0) begin
            $display("FAIL mid_restart: got addr=%0d valid=%b expected 20/0", rdaddr, out_valid); n_fail++;
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL mid_stale: got valid=%b d=%h expected 0", out_valid, out_data); n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 16'hA014 + 16'(i) || out_last !== (i == 2)) begin
                $display("FAIL mid_word%0d: got v=%b d=%h l=%b expected 1/%h/%b",
                         i, out_valid, out_data, out_last, 16'hA014 + 16'(i), (i == 2)); n_fail++;
            end
        end
        step(); step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
